// File: rtl/srp16_run_controller_if.sv
// Memory read port and dump stream of the SRP16 run controller.
// The controller is the master; the memory and the dump consumer sit on the slave side.
interface srp16_run_controller_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WIN_W  = 1
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              dump_valid;
    logic              dump_ready;
    logic [WIN_W-1:0]  dump_win;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;

    modport master (
        output mem_req, mem_addr,
        input  mem_ack, mem_rdata,
        output dump_valid, dump_win, dump_addr, dump_data,
        input  dump_ready
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_ack, mem_rdata,
        input  dump_valid, dump_win, dump_addr, dump_data,
        output dump_ready
    );
endinterface

// File: rtl/srp16_run_controller.sv
// Run/dump sequencer for SRP16: resets the core, gates its clock enable for a
// budget, until halt or by single steps, then streams memory windows to the host.
module srp16_run_controller #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int CYC_W      = 32,
    parameter int N_WIN      = 2,
    parameter int RST_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic [1:0]              mode,
    input  logic [CYC_W-1:0]        ncycles,
    input  logic                    step,
    input  logic                    cpu_halt,
    output logic                    cpu_rst_n,
    output logic                    cpu_ce,
    input  logic [N_WIN*ADDR_W-1:0] win_base,
    input  logic [N_WIN*ADDR_W-1:0] win_size,
    srp16_run_controller_if.master  bus,
    output logic [CYC_W-1:0]        cycle_count,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              status
);
    localparam int WIN_W = (N_WIN > 1) ? $clog2(N_WIN) : 1;
    localparam int RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [WIN_W-1:0] LAST_WIN = WIN_W'(N_WIN - 1);
    localparam logic [RC_W-1:0]  RST_LAST = RC_W'(RST_CYCLES - 1);

    localparam logic [1:0] ST_NONE   = 2'd0;
    localparam logic [1:0] ST_BUDGET = 2'd1;
    localparam logic [1:0] ST_HALT   = 2'd2;
    localparam logic [1:0] ST_ABORT  = 2'd3;

    localparam logic [1:0] MODE_BUDGET = 2'd0;
    localparam logic [1:0] MODE_STEP   = 2'd2;
    localparam logic [1:0] MODE_EITHER = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_STEP,
        S_SEL,
        S_REQ,
        S_OUT,
        S_DONE
    } state_t;

    state_t state, state_nxt;
    logic [1:0] status_nxt;
    logic       launch;

    logic [1:0]        mode_l;
    logic [CYC_W-1:0]  ncycles_l;
    logic [ADDR_W-1:0] base_l [N_WIN];
    logic [ADDR_W-1:0] size_l [N_WIN];

    logic [RC_W-1:0]   rst_cnt;
    logic              step_pend;
    logic [WIN_W-1:0]  win_idx;
    logic [ADDR_W-1:0] word_idx;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [WIN_W-1:0]  dump_win_r;
    logic [ADDR_W-1:0] dump_addr_r;
    logic [DATA_W-1:0] dump_data_r;
    logic              mem_req_c;
    logic              dump_valid_c;

    logic budget_on;
    logic halt_on;
    logic win_end;
    logic active;

    assign budget_on = (mode_l == MODE_BUDGET) || (mode_l == MODE_EITHER);
    assign halt_on   = mode_l[0];
    assign win_end   = (word_idx == size_l[win_idx]);
    assign active    = (state != S_IDLE) && (state != S_DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            status <= ST_NONE;
        end else begin
            state  <= state_nxt;
            status <= status_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        status_nxt   = status;
        launch       = 1'b0;
        cpu_rst_n    = 1'b1;
        cpu_ce       = 1'b0;
        mem_req_c    = 1'b0;
        dump_valid_c = 1'b0;
        busy         = active;
        done         = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                cpu_rst_n = (state == S_DONE);
                done      = (state == S_DONE);
                if (start && !abort) begin
                    state_nxt  = S_RESET;
                    status_nxt = ST_NONE;
                    launch     = 1'b1;
                end
            end
            S_RESET: begin
                cpu_rst_n = 1'b0;
                if (rst_cnt == RST_LAST) begin
                    if (mode_l == MODE_STEP) begin
                        state_nxt = S_STEP;
                    end else if (budget_on && (ncycles_l == '0)) begin
                        state_nxt  = S_SEL;
                        status_nxt = ST_BUDGET;
                    end else begin
                        state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                cpu_ce = 1'b1;
                // Halt takes priority when it coincides with the last budget cycle.
                if (halt_on && cpu_halt) begin
                    state_nxt  = S_SEL;
                    status_nxt = ST_HALT;
                end else if (budget_on && (cycle_count == ncycles_l - 1'b1)) begin
                    state_nxt  = S_SEL;
                    status_nxt = ST_BUDGET;
                end
            end
            S_STEP: begin
                cpu_ce = step_pend;
                if (cpu_halt) begin
                    state_nxt  = S_SEL;
                    status_nxt = ST_HALT;
                end
            end
            S_SEL: begin
                if (!win_end) begin
                    state_nxt = S_REQ;
                end else if (win_idx == LAST_WIN) begin
                    state_nxt = S_DONE;
                end
            end
            S_REQ: begin
                mem_req_c = 1'b1;
                if (bus.mem_ack) begin
                    state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                dump_valid_c = 1'b1;
                if (bus.dump_ready) begin
                    state_nxt = S_SEL;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (active && abort) begin
            state_nxt  = S_DONE;
            status_nxt = ST_ABORT;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_l      <= '0;
            ncycles_l   <= '0;
            for (int k = 0; k < N_WIN; k++) begin
                base_l[k] <= '0;
                size_l[k] <= '0;
            end
            rst_cnt     <= '0;
            step_pend   <= 1'b0;
            win_idx     <= '0;
            word_idx    <= '0;
            mem_addr_r  <= '0;
            dump_win_r  <= '0;
            dump_addr_r <= '0;
            dump_data_r <= '0;
            cycle_count <= '0;
        end else begin
            if (launch) begin
                mode_l      <= mode;
                ncycles_l   <= ncycles;
                for (int k = 0; k < N_WIN; k++) begin
                    base_l[k] <= win_base[k*ADDR_W +: ADDR_W];
                    size_l[k] <= win_size[k*ADDR_W +: ADDR_W];
                end
                rst_cnt     <= '0;
                win_idx     <= '0;
                word_idx    <= '0;
                cycle_count <= '0;
            end else if (cpu_ce && (cycle_count != '1)) begin
                cycle_count <= cycle_count + 1'b1;
            end

            if (state == S_RESET) begin
                rst_cnt <= rst_cnt + 1'b1;
            end

            // A sampled step pulse enables the core for exactly the following cycle.
            step_pend <= (state == S_STEP) && (state_nxt == S_STEP) && step;

            if (state == S_SEL) begin
                if (!win_end) begin
                    mem_addr_r <= base_l[win_idx] + word_idx;
                end else if (win_idx != LAST_WIN) begin
                    win_idx  <= win_idx + 1'b1;
                    word_idx <= '0;
                end
            end

            if ((state == S_REQ) && bus.mem_ack && !abort) begin
                dump_win_r  <= win_idx;
                dump_addr_r <= mem_addr_r;
                dump_data_r <= bus.mem_rdata;
            end

            if ((state == S_OUT) && bus.dump_ready && !abort) begin
                word_idx <= word_idx + 1'b1;
            end
        end
    end

    assign bus.mem_req    = mem_req_c;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.dump_valid = dump_valid_c;
    assign bus.dump_win   = dump_win_r;
    assign bus.dump_addr  = dump_addr_r;
    assign bus.dump_data  = dump_data_r;
endmodule

// File: tb/tb_srp16_run_controller.sv
// Scoreboard bench for srp16_run_controller: expected run results and dump words
// are queued at issue time and compared by monitors when the DUT presents them.
module tb_srp16_run_controller;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int CYC_W  = 32;
    localparam int N_WIN  = 2;
    localparam int LAT    = 2;

    typedef struct {
        logic [CYC_W-1:0] cc;
        logic [1:0]       st;
        int               ce;
        int               rl;
    } res_t;

    typedef struct {
        logic              win;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } dw_t;

    logic clk;
    logic reset;
    logic start, abort, step, cpu_halt;
    logic [1:0] mode;
    logic [CYC_W-1:0] ncycles;
    logic cpu_rst_n, cpu_ce, busy, done;
    logic [N_WIN*ADDR_W-1:0] win_base, win_size;
    logic [CYC_W-1:0] cycle_count;
    logic [1:0] status;

    srp16_run_controller_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WIN_W(1)) bus ();

    srp16_run_controller #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CYC_W(CYC_W), .N_WIN(N_WIN), .RST_CYCLES(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
        .ncycles(ncycles), .step(step), .cpu_halt(cpu_halt), .cpu_rst_n(cpu_rst_n),
        .cpu_ce(cpu_ce), .win_base(win_base), .win_size(win_size), .bus(bus),
        .cycle_count(cycle_count), .busy(busy), .done(done), .status(status)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    res_t rq[$];
    dw_t  dq[$];

    int   halt_at  = 0;
    logic halt_now = 1'b0;
    logic halt_hit = 1'b0;
    logic rdy_rand = 1'b0;
    assign cpu_halt = halt_hit | halt_now;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endfunction

    function automatic logic [DATA_W-1:0] memval(logic [ADDR_W-1:0] a);
        return a ^ 16'hA5C3;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory: acknowledges a request LAT cycles after it appears, one-cycle ack pulse.
    initial begin
        int lat;
        lat = 0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (bus.mem_ack) begin
                bus.mem_ack = 1'b0;
                lat = 0;
            end else if (bus.mem_req) begin
                lat++;
                if (lat >= LAT) begin
                    bus.mem_ack = 1'b1;
                    bus.mem_rdata = memval(bus.mem_addr);
                    lat = 0;
                end
            end else begin
                lat = 0;
            end
        end
    end

    initial begin
        bus.dump_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus.dump_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Raises cpu_halt inside the halt_at-th enabled cycle of the current run.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (!busy) begin
                cnt = 0;
                halt_hit = 1'b0;
            end else if (cpu_ce) begin
                cnt++;
                if (halt_at != 0 && cnt == halt_at) halt_hit = 1'b1;
            end
        end
    end

    initial begin
        logic prev_done, prev_busy;
        int ce_n, rl_n;
        res_t r;
        dw_t d;
        prev_done = 1'b0;
        prev_busy = 1'b0;
        ce_n = 0;
        rl_n = 0;
        forever begin
            @(negedge clk);
            if (busy && !prev_busy) begin
                ce_n = 0;
                rl_n = 0;
            end
            if (cpu_ce) ce_n++;
            if (busy && !cpu_rst_n) rl_n++;
            if (bus.dump_valid && bus.dump_ready) begin
                check("no_req_during_valid", 64'(bus.mem_req), 64'd0);
                if (dq.size() == 0) begin
                    check("unexpected_dump_word", 64'(bus.dump_addr), 64'hFFFF_FFFF);
                end else begin
                    d = dq.pop_front();
                    check("dump_win", 64'(bus.dump_win), 64'(d.win));
                    check("dump_addr", 64'(bus.dump_addr), 64'(d.addr));
                    check("dump_data", 64'(bus.dump_data), 64'(d.data));
                end
            end
            if (done && !prev_done) begin
                if (rq.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'd0);
                end else begin
                    r = rq.pop_front();
                    check("cycle_count", 64'(cycle_count), 64'(r.cc));
                    check("status", 64'(status), 64'(r.st));
                    check("ce_cycles", 64'(ce_n), 64'(r.ce));
                    check("rst_low_cycles", 64'(rl_n), 64'(r.rl));
                    check("dump_queue_drained", 64'(dq.size()), 64'd0);
                end
            end
            prev_done = done;
            prev_busy = busy;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic launch(input logic [1:0] m, input logic [CYC_W-1:0] n,
                          input logic [N_WIN*ADDR_W-1:0] b, input logic [N_WIN*ADDR_W-1:0] s);
        mode = m;
        ncycles = n;
        win_base = b;
        win_size = s;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic expect_run(input logic [CYC_W-1:0] cc, input logic [1:0] st,
                              input int ce, input int rl);
        res_t r;
        r.cc = cc; r.st = st; r.ce = ce; r.rl = rl;
        rq.push_back(r);
    endtask

    task automatic expect_word(input logic w, input logic [ADDR_W-1:0] a);
        dw_t d;
        d.win = w; d.addr = a; d.data = memval(a);
        dq.push_back(d);
    endtask

    task automatic wait_done(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (done) break;
            tick();
        end
        if (i == budget) check({name, "_timeout"}, 64'(done), 64'd1);
        tick();
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0; abort = 1'b0; step = 1'b0;
        mode = 2'd0; ncycles = '0; win_base = '0; win_size = '0;
        repeat (3) tick();
        check("rst_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        check("rst_cpu_ce", 64'(cpu_ce), 64'd0);
        check("rst_busy_done", 64'({busy, done}), 64'd0);
        check("rst_status", 64'(status), 64'd0);
        check("rst_mem", 64'({bus.mem_req, bus.dump_valid, bus.mem_addr}), 64'd0);
        check("rst_dump", 64'({bus.dump_win, bus.dump_addr, bus.dump_data}), 64'd0);
        reset = 1'b1;
        tick();

        // Budget run, no windows.
        halt_at = 0;
        expect_run(10, 2'd1, 10, 2);
        launch(2'd0, 10, '0, '0);
        wait_done("budget10", 200);

        // Run until halt on 7th enabled cycle.
        halt_at = 7;
        expect_run(7, 2'd2, 7, 2);
        launch(2'd1, 0, '0, '0);
        wait_done("halt7", 200);

        // Halt and budget expiring together: halt wins.
        expect_run(7, 2'd2, 7, 2);
        launch(2'd3, 7, '0, '0);
        wait_done("both7", 200);
        halt_at = 0;

        // Dump with wrapping second window and random consumer back-pressure.
        rdy_rand = 1'b1;
        expect_run(3, 2'd1, 3, 2);
        expect_word(1'b0, 16'h0010);
        expect_word(1'b0, 16'h0011);
        expect_word(1'b0, 16'h0012);
        expect_word(1'b1, 16'hFFFF);
        expect_word(1'b1, 16'h0000);
        launch(2'd0, 3, {16'hFFFF, 16'h0010}, {16'd2, 16'd3});
        wait_done("dump", 1000);
        rdy_rand = 1'b0;

        // Single step: three pulses with gaps, then halt.
        expect_run(3, 2'd2, 3, 2);
        launch(2'd2, 0, '0, '0);
        for (int i = 0; i < 20 && !cpu_rst_n; i++) tick();
        for (int p = 0; p < 3; p++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            repeat (3) tick();
        end
        halt_now = 1'b1;
        wait_done("step", 200);
        halt_now = 1'b0;

        // Abort while a memory request is outstanding.
        expect_run(2, 2'd3, 2, 2);
        launch(2'd0, 2, {16'h0000, 16'h0020}, {16'd0, 16'd3});
        for (int i = 0; i < 50 && !bus.mem_req; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_done", 64'(done), 64'd1);
        check("abort_status", 64'(status), 64'd3);
        check("abort_req_valid", 64'({bus.mem_req, bus.dump_valid}), 64'd0);
        repeat (4) tick();
        check("abort_stays_done", 64'({done, bus.dump_valid}), 64'b10);

        // Restart with zero budget: straight to dump.
        expect_run(0, 2'd1, 0, 2);
        expect_word(1'b0, 16'h0100);
        launch(2'd0, 0, {16'h0000, 16'h0100}, {16'd0, 16'd1});
        wait_done("zero_budget", 200);

        // Asynchronous reset in the middle of a run.
        launch(2'd1, 0, '0, '0);
        repeat (6) tick();
        #2 reset = 1'b0;
        #1;
        check("amid_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        check("amid_cpu_ce", 64'(cpu_ce), 64'd0);
        check("amid_busy_done", 64'({busy, done}), 64'd0);
        check("amid_count_status", 64'({cycle_count, status}), 64'd0);
        tick();
        reset = 1'b1;
        tick();

        // start together with abort in IDLE is ignored.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        tick();
        check("start_abort_ignored", 64'({busy, done, cpu_rst_n}), 64'd0);

        expect_run(5, 2'd1, 5, 2);
        launch(2'd0, 5, '0, '0);
        wait_done("after_reset", 200);

        repeat (3) tick();
        check("results_drained", 64'(rq.size()), 64'd0);
        check("words_drained", 64'(dq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
